stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter ONES_MAX, default 9, terminal value of the ones digit (ones counts modulo ONES_MAX+1).
REQ-002 Parameter TENS_MAX, default 5, terminal value of the tens digit (tens counts modulo TENS_MAX+1).
REQ-003 clockIn  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  count-enable strobe, one count per cycle it is high.
REQ-006 start  input  1  command: begin or resume counting.
REQ-007 stop  input  1  command: pause counting.
REQ-008 clear  input  1  command: abort, zero the count, return to IDLE.
REQ-009 target_ones  input  4  ones digit of the terminal count.
REQ-010 target_tens  input  4  tens digit of the terminal count.
REQ-011 ones  output  4  current ones digit, registered.
REQ-012 tens  output  4  current tens digit, registered.
REQ-013 state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-014 running  output  1  high exactly when state is RUN.
REQ-015 done  output  1  one-cycle pulse on reaching the target.
REQ-016 wrap  output  1  one-cycle pulse on rollover from TENS_MAX:ONES_MAX to 0:0.

Function
REQ-017 Command priority SHALL be clear > stop > start > tick, evaluated every cycle.
REQ-018 clear in any state SHALL give, next cycle: state IDLE, ones=0, tens=0, done=0, wrap=0.
REQ-019 IDLE: counts held at 0:0; start SHALL latch target_ones/target_tens internally and move to RUN.
REQ-020 RUN: stop SHALL move to PAUSE with the count unchanged, even if tick is high in the same cycle.
REQ-021 RUN, tick high, no stop/clear: ones SHALL increment next cycle; at ONES_MAX ones goes to 0 and tens increments.
REQ-022 Tens at TENS_MAX and ones at ONES_MAX, with tick: both digits SHALL go to 0 and wrap SHALL pulse the same cycle.
REQ-023 Once the post-increment count equals the latched target, state SHALL go to DONE and done SHALL pulse high for one cycle, coincident with the new count.
REQ-024 done and wrap SHALL both pulse in the same cycle when the target is 0:0 and the rollover occurs.
REQ-025 A target digit outside its range (ones>ONES_MAX or tens>TENS_MAX) SHALL never match; counting continues with wraps indefinitely.
REQ-026 PAUSE: count held; start SHALL return to RUN without re-latching the target; tick ignored.
REQ-027 DONE: count held; start, stop and tick SHALL be ignored; only clear or reset exits.
REQ-028 Changes to target_* after latching SHALL have no effect until the next IDLE->RUN transition.
REQ-029 tick outside RUN SHALL have no effect on any output.

Reset
REQ-030 reset high at a clock edge SHALL give, next cycle: state IDLE, ones=0, tens=0, latched target=0:0, running=0, done=0, wrap=0.
REQ-031 reset SHALL override every command, including clear and start asserted in the same cycle.
REQ-032 Reset asserted mid-RUN SHALL abort the count with no done or wrap pulse.

Verification
REQ-033 Reset, target 0:3, start, tick every cycle -> counts 0:1, 0:2, 0:3; done pulses with 0:3; state DONE; further ticks leave 0:3.
REQ-034 Target 0:0, start, 60 ticks -> 60th tick gives count 0:0 with wrap=1 and done=1 in the same cycle; state DONE.
REQ-035 RUN at 1:4, stop and tick in the same cycle -> PAUSE, count 1:4; start -> RUN; next tick -> 1:5.
REQ-036 RUN at 2:7, clear and tick in the same cycle -> IDLE, 0:0, no done.
REQ-037 Target tens=6, ones=0 (out of range), 130 ticks -> wrap pulses after the 60th and 120th ticks; done never asserts; final count 1:0.
REQ-038 RUN at 3:2, reset with start held high -> next cycle IDLE, 0:0; first cycle after reset deasserts with start high -> RUN.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Command, target and status signals of the two-digit stopwatch controller.
// master drives commands and the target; slave returns the count and status.
interface stopwatch_ctrl_if;
    logic       tick;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] target_ones;
    logic [3:0] target_tens;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [1:0] state;
    logic       running;
    logic       done;
    logic       wrap;

    modport master (
        output tick, start, stop, clear, target_ones, target_tens,
        input  ones, tens, state, running, done, wrap
    );

    modport slave (
        input  tick, start, stop, clear, target_ones, target_tens,
        output ones, tens, state, running, done, wrap
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD-style stopwatch with IDLE/RUN/PAUSE/DONE control, a latched
// terminal count, and one-cycle done/wrap pulses registered with the count.
module stopwatch_ctrl #(
    parameter int ONES_MAX = 9,
    parameter int TENS_MAX = 5
) (
    input  logic          clockIn,
    input  logic          reset,
    stopwatch_ctrl_if.slave sw
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [3:0] ONES_TOP = 4'(ONES_MAX);
    localparam logic [3:0] TENS_TOP = 4'(TENS_MAX);

    state_t     state_q, state_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] tgt_ones_q, tgt_ones_d;
    logic [3:0] tgt_tens_q, tgt_tens_d;
    logic       done_q, done_d;
    logic       wrap_q, wrap_d;

    logic [3:0] inc_ones;
    logic [3:0] inc_tens;
    logic       inc_wrap;

    always_comb begin
        inc_ones = ones_q + 4'd1;
        inc_tens = tens_q;
        inc_wrap = 1'b0;
        if (ones_q == ONES_TOP) begin
            inc_ones = 4'd0;
            if (tens_q == TENS_TOP) begin
                inc_tens = 4'd0;
                inc_wrap = 1'b1;
            end else begin
                inc_tens = tens_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (reset) begin
            state_q    <= IDLE;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
            tgt_ones_q <= 4'd0;
            tgt_tens_q <= 4'd0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            tgt_ones_q <= tgt_ones_d;
            tgt_tens_q <= tgt_tens_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
        end
    end

    // An out-of-range target digit can never equal a count digit, so it simply never matches.
    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        tgt_ones_d = tgt_ones_q;
        tgt_tens_d = tgt_tens_q;
        done_d     = 1'b0;
        wrap_d     = 1'b0;
        if (sw.clear) begin
            state_d = IDLE;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!sw.stop && sw.start) begin
                        state_d    = RUN;
                        tgt_ones_d = sw.target_ones;
                        tgt_tens_d = sw.target_tens;
                    end
                end
                RUN: begin
                    if (sw.stop) begin
                        state_d = PAUSE;
                    end else if (sw.tick) begin
                        ones_d = inc_ones;
                        tens_d = inc_tens;
                        wrap_d = inc_wrap;
                        if (inc_ones == tgt_ones_q && inc_tens == tgt_tens_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!sw.stop && sw.start) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sw.ones    = ones_q;
        sw.tens    = tens_q;
        sw.state   = state_q;
        sw.running = (state_q == RUN);
        sw.done    = done_q;
        sw.wrap    = wrap_q;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one task per scenario, inline compares.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [14:0] exp_v;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.ONES_MAX(9), .TENS_MAX(5)) dut (
        .clockIn (clk),
        .reset   (reset),
        .sw      (sw)
    );

    always #5 clk = ~clk;

    wire [14:0] obs = {sw.state, sw.tens, sw.ones, sw.running, sw.done, sw.wrap};

    function automatic logic [14:0] pk(input logic [1:0] st, input int t, input int o,
                                       input logic d, input logic w);
        return {st, 4'(t), 4'(o), (st == 2'b01), d, w};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sw.tick = 0; sw.start = 0; sw.stop = 0; sw.clear = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic start_run(input int tt, input int to);
        sw.target_tens = 4'(tt); sw.target_ones = 4'(to);
        sw.start = 1;
        step();
        sw.start = 0;
    endtask

    task automatic run_ticks(input int n);
        sw.tick = 1;
        repeat (n) step();
        sw.tick = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        sw.target_tens = 0; sw.target_ones = 0;
        reset = 1;
        step();
        exp_v = pk(2'b00, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_state got %h exp %h", obs, exp_v); end
        sw.clear = 1; sw.start = 1; sw.tick = 1;
        step();
        exp_v = pk(2'b00, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_over_cmds got %h exp %h", obs, exp_v); end
        idle_inputs();
        reset = 0;
        sw.tick = 1;
        step();
        exp_v = pk(2'b00, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL idle_tick_ignored got %h exp %h", obs, exp_v); end
        sw.tick = 0;
    endtask

    task automatic test_count_to_target();
        do_reset();
        start_run(0, 3);
        exp_v = pk(2'b01, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_start got %h exp %h", obs, exp_v); end
        sw.tick = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_v = (k == 3) ? pk(2'b11, 0, 3, 1, 0) : pk(2'b01, 0, k, 0, 0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_tick%0d got %h exp %h", k, obs, exp_v); end
        end
        step();
        exp_v = pk(2'b11, 0, 3, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_done_hold got %h exp %h", obs, exp_v); end
        sw.start = 1; sw.stop = 1;
        step();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_done_ignores got %h exp %h", obs, exp_v); end
        idle_inputs();
        sw.clear = 1;
        step();
        sw.clear = 0;
        exp_v = pk(2'b00, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL t3_clear_exit got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_wrap_done();
        do_reset();
        start_run(0, 0);
        sw.tick = 1;
        for (int k = 1; k <= 60; k++) begin
            step();
            exp_v = (k == 60) ? pk(2'b11, 0, 0, 1, 1) : pk(2'b01, k / 10, k % 10, 0, 0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrapdone_tick%0d got %h exp %h", k, obs, exp_v); end
        end
        step();
        exp_v = pk(2'b11, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrapdone_hold got %h exp %h", obs, exp_v); end
        sw.tick = 0;
    endtask

    task automatic test_stop_resume();
        do_reset();
        start_run(5, 9);
        run_ticks(14);
        exp_v = pk(2'b01, 1, 4, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL sr_at_14 got %h exp %h", obs, exp_v); end
        sw.stop = 1; sw.tick = 1;
        step();
        sw.stop = 0;
        exp_v = pk(2'b10, 1, 4, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL sr_pause got %h exp %h", obs, exp_v); end
        step();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL sr_pause_tick got %h exp %h", obs, exp_v); end
        sw.tick = 0; sw.start = 1;
        step();
        sw.start = 0;
        exp_v = pk(2'b01, 1, 4, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL sr_resume got %h exp %h", obs, exp_v); end
        run_ticks(1);
        exp_v = pk(2'b01, 1, 5, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL sr_next got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_clear_run();
        do_reset();
        start_run(5, 9);
        run_ticks(27);
        exp_v = pk(2'b01, 2, 7, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL clr_at_27 got %h exp %h", obs, exp_v); end
        sw.clear = 1; sw.tick = 1;
        step();
        idle_inputs();
        exp_v = pk(2'b00, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL clr_idle got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_target_latch();
        do_reset();
        start_run(0, 5);
        sw.target_tens = 0; sw.target_ones = 2;
        run_ticks(2);
        exp_v = pk(2'b01, 0, 2, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL latch_no_early got %h exp %h", obs, exp_v); end
        run_ticks(3);
        exp_v = pk(2'b11, 0, 5, 1, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL latch_done got %h exp %h", obs, exp_v); end
    endtask

    task automatic test_out_of_range();
        int wraps;
        int dones;
        wraps = 0; dones = 0;
        do_reset();
        start_run(6, 0);
        sw.tick = 1;
        for (int k = 1; k <= 130; k++) begin
            step();
            if (sw.wrap === 1'b1) wraps++;
            if (sw.done === 1'b1) dones++;
            exp_v = pk(2'b01, (k % 60) / 10, k % 10, 0, (k % 60) == 0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL oor_tick%0d got %h exp %h", k, obs, exp_v); end
        end
        sw.tick = 0;
        checks++; if (wraps != 2) begin errors++; $display("FAIL oor_wrap_count got %0d exp 2", wraps); end
        checks++; if (dones != 0) begin errors++; $display("FAIL oor_done_count got %0d exp 0", dones); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        start_run(5, 9);
        run_ticks(32);
        exp_v = pk(2'b01, 3, 2, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL rmr_at_32 got %h exp %h", obs, exp_v); end
        reset = 1; sw.start = 1; sw.tick = 1;
        step();
        sw.tick = 0;
        exp_v = pk(2'b00, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL rmr_reset got %h exp %h", obs, exp_v); end
        reset = 0;
        step();
        sw.start = 0;
        exp_v = pk(2'b01, 0, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL rmr_restart got %h exp %h", obs, exp_v); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        sw.target_tens = 0; sw.target_ones = 0;
        test_reset();
        test_count_to_target();
        test_wrap_done();
        test_stop_resume();
        test_clear_run();
        test_target_latch();
        test_out_of_range();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
